// File: rtl/ldm_write_sequencer.sv
// ldm_write_sequencer: write-port driver for load-multiple transfers.
// Each accepted data word is written to the lowest-numbered register still
// pending in the captured list, so registers fill in ascending order.
// Optional feature macro: LDM_PC_WRITE_EN (when defined, bit 15 / PC is
// writable like any other register; when undefined, bit 15 is dropped at capture).
module ldm_write_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           reglist,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [ADDR_WIDTH-1:0] rw,
  output logic [DATA_WIDTH-1:0] pw,
  output logic                  le,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            count
);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t                state, state_nxt;
  logic [15:0]           pend, pend_nxt, cap_list;
  logic [ADDR_WIDTH-1:0] tgt;
  logic                  take;

  // list as captured: PC bit dropped unless PC writes are enabled
`ifdef LDM_PC_WRITE_EN
  assign cap_list = reglist;
`else
  assign cap_list = {1'b0, reglist[14:0]};
`endif

  // lowest pending register wins (scan from top so the lowest set bit is last)
  always_comb begin
    tgt = '0;
    for (int i = 15; i >= 0; i--)
      if (pend[i]) tgt = ADDR_WIDTH'(i);
  end

  assign take = (state == XFER) && din_valid;

  // next-state, pending-mask update and status outputs
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    din_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          pend_nxt  = cap_list;
          state_nxt = (|cap_list) ? XFER : FIN;
        end
      end
      XFER: begin
        din_ready = 1'b1;
        if (din_valid) begin
          pend_nxt = pend & ~(16'd1 << tgt);
          if (pend_nxt == 16'd0) state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, mask, counter and registered write port; rw/pw hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      count <= '0;
      rw    <= '0;
      pw    <= '0;
      le    <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      le    <= take;
      if (take) begin
        rw    <= tgt;
        pw    <= din;
        count <= count + 5'd1;
      end else if (state == IDLE && start) begin
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ldm_write_sequencer.sv
// Self-checking bench for ldm_write_sequencer: directed test-plan steps plus
// random lists, compared against a queue-based model of the expected writes.
module tb_ldm_write_sequencer;

`ifdef LDM_PC_WRITE_EN
  localparam bit PCEN = 1'b1;
`else
  localparam bit PCEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] reglist;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [3:0]  rw;
  logic [31:0] pw;
  logic        le;
  logic        busy;
  logic        done;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;
  int m_rw = 0;
  logic [31:0] m_pw = '0;

  ldm_write_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reglist(reglist),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .rw(rw), .pw(pw), .le(le), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 random valid, 1 valid held high, 2 valid toggling, 3 five-cycle stall
  // base != 0: k-th accepted word is base+k; base == 0: random words
  // noise: hold start=1 with reglist=16'h8000 throughout the transfer
  task automatic do_xfer(input logic [15:0] list, input int mode,
                         input logic [31:0] base, input bit noise);
    int q[$];
    int n, acc, cyc;
    logic [31:0] w;
    bit v, pend_le;
    for (int i = 0; i < 16; i++)
      if (list[i] && (i != 15 || PCEN)) q.push_back(i);
    n = q.size(); acc = 0; cyc = 0; pend_le = 0;
    @(negedge clk); start = 1'b1; reglist = list; din_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    if (n == 0) begin
      chk("empty_done", done, 1);  chk("empty_busy", busy, 1);
      chk("empty_rdy", din_ready, 0); chk("empty_le", le, 0);
      chk("empty_cnt", count, 0);
      @(negedge clk);
      chk("empty_idle_busy", busy, 0); chk("empty_idle_done", done, 0);
      chk("empty_idle_rdy", din_ready, 0); chk("empty_idle_le", le, 0);
      return;
    end
    while (q.size() > 0) begin
      chk("x_rdy", din_ready, 1); chk("x_busy", busy, 1); chk("x_done", done, 0);
      chk("x_le", le, pend_le);   chk("x_rw", rw, m_rw);   chk("x_pw", pw, m_pw);
      chk("x_cnt", count, acc);
      start = noise; reglist = 16'h8000;
      case (mode)
        1:       v = 1'b1;
        2:       v = (cyc % 2 == 0);
        3:       v = (cyc >= 5);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (cyc > 40) v = 1'b1;
      w = (base != 0) ? base + 32'(acc) : $urandom;
      din_valid = v; din = w;
      if (v) begin m_rw = q.pop_front(); m_pw = w; acc++; end
      pend_le = v; cyc++;
      @(negedge clk);
    end
    start = 1'b0; din_valid = 1'b0;
    chk("fin_le", le, 1);     chk("fin_rw", rw, m_rw); chk("fin_pw", pw, m_pw);
    chk("fin_done", done, 1); chk("fin_busy", busy, 1); chk("fin_rdy", din_ready, 0);
    chk("fin_cnt", count, n);
    @(negedge clk);
    chk("post_busy", busy, 0); chk("post_done", done, 0); chk("post_le", le, 0);
    chk("post_cnt", count, n); chk("post_rw", rw, m_rw); chk("post_pw", pw, m_pw);
    chk("post_rdy", din_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; reglist = '0; din = '0; din_valid = 1'b0;
    #1;
    chk("rst_rdy", din_ready, 0); chk("rst_rw", rw, 0); chk("rst_pw", pw, 0);
    chk("rst_le", le, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_cnt", count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // two-register list, back-to-back words A, B
    do_xfer(16'h0005, 1, 32'hA, 1'b0);
    // empty list and PC-only list
    do_xfer(16'h0000, 1, 32'h0, 1'b0);
    do_xfer(16'h8000, 1, 32'h0, 1'b0);
    // full list with toggling valid, words 100..115
    do_xfer(16'hFFFF, 2, 32'd100, 1'b0);
    // backpressure: five idle cycles then 0xDEAD into R8
    do_xfer(16'h0100, 3, 32'hDEAD, 1'b0);
    // start while busy is ignored
    do_xfer(16'h0003, 1, 32'h0, 1'b1);

    // reset mid-transfer after two accepted words
    @(negedge clk); start = 1'b1; reglist = 16'h000F;
    @(negedge clk); start = 1'b0; din_valid = 1'b1; din = 32'h11;
    @(negedge clk); din = 32'h22;
    @(negedge clk); din_valid = 1'b0;
    chk("mid_le", le, 1); chk("mid_cnt", count, 2); chk("mid_pw", pw, 32'h22);
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", din_ready, 0); chk("arst_rw", rw, 0); chk("arst_pw", pw, 0);
    chk("arst_le", le, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    chk("arst_cnt", count, 0);
    repeat (2) @(negedge clk);
    chk("arst_hold_done", done, 0); chk("arst_hold_le", le, 0);
    rst_n = 1'b1; m_rw = 0; m_pw = '0;
    do_xfer(16'h0002, 1, 32'h0, 1'b0);

    // random lists, random valid, occasional stray start
    for (int t = 0; t < 25; t++)
      do_xfer(16'($urandom), 0, 32'h0, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
